ldpc_acc_scheduler: RTL and testbench

Sequencing controller for the LDPC check-node accumulator. It executes one job per start command. A job streams `i_count` operand words from a message RAM into the accumulator. It tracks each word through the fixed RAM and accumulator latency, buffers the results in a small FIFO, and writes them to a destination RAM through a ready/valid port. Credit-based issue prevents FIFO overflow under write backpressure.

---
 rtl/ldpc_acc_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_ldpc_acc_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_acc_scheduler.sv
// Job sequencer for the LDPC check-node accumulator: issues RAM reads under a credit limit,
// tags each word through RAM + accumulator latency, and drains results through a FWFT FIFO.
module ldpc_acc_scheduler #(
    parameter int unsigned NUM_INPUTS  = 6,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_WORDS),
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ACC_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_src_base,
    input  logic [ADDR_WIDTH-1:0]            i_dst_base,
    input  logic [ADDR_WIDTH:0]              i_count,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_rd_en,
    output logic [ADDR_WIDTH-1:0]            o_rd_addr,
    input  logic [NUM_INPUTS*WIDTH-1:0]      i_rd_data,
    output logic [NUM_INPUTS*WIDTH-1:0]      o_acc_data,
    input  logic [NUM_INPUTS*WIDTH-1:0]      i_acc_data,
    output logic                             o_wr_valid,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [NUM_INPUTS*WIDTH-1:0]      o_wr_data,
    input  logic                             i_wr_ready
);
    localparam int unsigned DATA_W  = NUM_INPUTS * WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned TAG_LEN = RAM_LATENCY + 1 + ACC_LATENCY;
    localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, rd_dst_q, rd_dst_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [TAG_LEN-1:0]  tag_vld_q, tag_vld_d;
    logic [ADDR_WIDTH-1:0] tag_addr_q [TAG_LEN];
    logic [ADDR_WIDTH-1:0] tag_addr_d [TAG_LEN];
    logic [DATA_W-1:0]   acc_data_q, acc_data_d;
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CRED_W-1:0]   fifo_cnt_q, fifo_cnt_d, cnt_after_pop;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    count_clamped;
    logic [CRED_W-1:0]   credits_after;
    logic                issue, pop, push;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Control FSM; credits are reserved when a read is decided, so the limit holds one cycle ahead
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rd_addr_d     = rd_addr_q;
        rd_dst_d      = rd_dst_q;
        issue         = 1'b0;
        pop           = wr_valid_q & i_wr_ready;
        credits_after = credits_q - CRED_W'(pop);
        count_clamped = (i_count > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS) : i_count;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (count_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        issue     = 1'b1;
                        rd_addr_d = i_src_base;
                        src_d     = addr_inc(i_src_base);
                        rd_dst_d  = i_dst_base;
                        dst_d     = addr_inc(i_dst_base);
                        rem_d     = count_clamped - CNT_W'(1);
                        state_d   = (count_clamped == CNT_W'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credits_after < CRED_W'(FIFO_DEPTH)) begin
                    issue     = 1'b1;
                    rd_addr_d = src_q;
                    src_d     = addr_inc(src_q);
                    rd_dst_d  = dst_q;
                    dst_d     = addr_inc(dst_q);
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credits_after == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        credits_d = credits_after + CRED_W'(issue);
        rd_en_d   = issue;
        busy_d    = (state_d == ISSUE) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    // Tag pipeline, accumulator input gating and result FIFO
    always_comb begin
        tag_vld_d     = {tag_vld_q[TAG_LEN-2:0], rd_en_q};
        tag_addr_d[0] = rd_dst_q;
        for (int i = 1; i < TAG_LEN; i++) begin
            tag_addr_d[i] = tag_addr_q[i-1];
        end
        acc_data_d = tag_vld_q[RAM_LATENCY-1] ? i_rd_data : '0;

        push        = tag_vld_q[TAG_LEN-1];
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = i_acc_data;
            fifo_addr_d[wr_ptr_q] = tag_addr_q[TAG_LEN-1];
        end
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_after_pop = fifo_cnt_q - CRED_W'(pop);
        fifo_cnt_d    = cnt_after_pop + CRED_W'(push);
        wr_valid_d    = (fifo_cnt_d != '0);
        wr_addr_d     = '0;
        wr_data_d     = '0;
        // Head register: an entry pushed into an otherwise-empty FIFO becomes the head directly
        if (cnt_after_pop == '0) begin
            if (push) begin
                wr_addr_d = tag_addr_q[TAG_LEN-1];
                wr_data_d = i_acc_data;
            end
        end else begin
            wr_addr_d = fifo_addr_q[rd_ptr_d];
            wr_data_d = fifo_data_q[rd_ptr_d];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_dst_q   <= '0;
            credits_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tag_vld_q  <= '0;
            acc_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < TAG_LEN; i++) begin
                tag_addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_dst_q   <= rd_dst_d;
            credits_q  <= credits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tag_vld_q  <= tag_vld_d;
            acc_data_q <= acc_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tag_addr_q <= tag_addr_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone qualifies it
    always_ff @(posedge i_clock) begin
        fifo_data_q <= fifo_data_d;
        fifo_addr_q <= fifo_addr_d;
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rd_en    = rd_en_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_acc_data = acc_data_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
endmodule

// File: tb/tb_ldpc_acc_scheduler.sv
// Scoreboard bench for ldpc_acc_scheduler with a 1-cycle RAM model and a 4-stage accumulator model.
module tb_ldpc_acc_scheduler;
    localparam int AW = 10;
    localparam int DW = 96;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_src_base = '0;
    logic [AW-1:0] i_dst_base = '0;
    logic [AW:0]   i_count = '0;
    logic          o_busy, o_done, o_rd_en, o_wr_valid;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [DW-1:0] i_rd_data, o_acc_data, i_acc_data, o_wr_data;
    logic          i_wr_ready = 1'b1;

    ldpc_acc_scheduler dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_src_base(i_src_base), .i_dst_base(i_dst_base), .i_count(i_count),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_acc_data(o_acc_data), .i_acc_data(i_acc_data),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .i_wr_ready(i_wr_ready)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {6{6'h2A, a}};
    endfunction

    // Message RAM: one-cycle read latency, garbage when not read
    always @(posedge i_clock) begin
        if (o_rd_en) i_rd_data <= ram_word(o_rd_addr);
        else         i_rd_data <= {6{16'hBEEF}};
    end

    // Accumulator stand-in: bitwise invert, four-cycle latency, shares reset
    logic [DW-1:0] acc_pipe [4];
    always @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) acc_pipe[i] <= '0;
        end else begin
            acc_pipe[0] <= ~o_acc_data;
            for (int i = 1; i < 4; i++) acc_pipe[i] <= acc_pipe[i-1];
        end
    end
    assign i_acc_data = acc_pipe[3];

    int checks = 0;
    int errors = 0;
    logic [AW-1:0]    rd_exp [$];
    logic [AW+DW-1:0] wr_exp [$];
    int rd_cnt, wr_cnt, done_cnt = 0, done_snap, first_rd, first_wr, last_wr, done_cyc, wr_valid_cnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks read order, hold and done/busy
    logic             held = 1'b0;
    logic [AW-1:0]    h_addr;
    logic [DW-1:0]    h_data;
    logic [AW+DW-1:0] e;
    always @(negedge i_clock) begin
        if (i_reset) begin
            held = 1'b0;
        end else begin
            if (held) check("wr_hold", {o_wr_valid, o_wr_addr, o_wr_data}, {1'b1, h_addr, h_data});
            held   = o_wr_valid && !i_wr_ready;
            h_addr = o_wr_addr;
            h_data = o_wr_data;
            if (o_wr_valid) wr_valid_cnt++;
            if (o_wr_valid && i_wr_ready) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (wr_exp.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = wr_exp.pop_front();
                    check("wr_addr", o_wr_addr, e[AW+DW-1:DW]);
                    check("wr_data", o_wr_data, e[DW-1:0]);
                end
            end
            if (o_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (rd_exp.size() == 0) check("unexpected_read", 1, 0);
                else                    check("rd_addr", o_rd_addr, rd_exp.pop_front());
                check("outstanding_le_8", (rd_cnt - wr_cnt) <= 8, 1);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", o_busy, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic start_job(input int src, input int dst, input int cnt, output int c);
        int n;
        n = (cnt > 1024) ? 1024 : cnt;
        for (int k = 0; k < n; k++) begin
            rd_exp.push_back(AW'((src + k) % 1024));
            wr_exp.push_back({AW'((dst + k) % 1024), ~ram_word(AW'((src + k) % 1024))});
        end
        rd_cnt = 0; wr_cnt = 0; first_rd = -1; first_wr = -1; last_wr = -1;
        done_snap  = done_cnt;
        i_src_base = AW'(src);
        i_dst_base = AW'(dst);
        i_count    = 11'(cnt);
        i_start    = 1'b1;
        c = cyc;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max && done_cnt == done_snap; i++) tick(1);
        check("done_seen", done_cnt == done_snap + 1, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl"}, {o_busy, o_done, o_rd_en, o_rd_addr, o_wr_valid, o_wr_addr}, 0);
        check({tag, "_data"}, {o_acc_data, o_wr_data}, 0);
    endtask

    initial begin
        int c;
        tick(3);
        check_zero_outputs("reset");
        i_reset = 1'b0;
        tick(2);

        // Basic job
        start_job(0, 100, 4, c);
        wait_done(40);
        check("basic_first_rd", first_rd, c + 1);
        check("basic_first_wr", first_wr, c + 8);
        check("basic_last_wr", last_wr, c + 11);
        check("basic_done_cyc", done_cyc, c + 12);
        check("basic_wr_cnt", wr_cnt, 4);
        tick(2);

        // Address wrap-around
        start_job(1022, 1023, 3, c);
        wait_done(40);
        check("wrap_wr_cnt", wr_cnt, 3);
        check("wrap_done_cyc", done_cyc, c + 11);
        tick(2);

        // Zero count
        start_job(5, 5, 0, c);
        wait_done(10);
        check("zero_done_cyc", done_cyc, c + 1);
        check("zero_rd_cnt", rd_cnt, 0);
        tick(2);

        // Backpressure with an ignored second start during ISSUE
        start_job(200, 300, 20, c);
        i_wr_ready = 1'b0;
        tick(1);
        i_src_base = AW'(700); i_dst_base = AW'(900); i_count = 11'(5); i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(30);
        check("bp_rd_cnt_stalled", rd_cnt, 8);
        check("bp_wr_cnt_stalled", wr_cnt, 0);
        i_wr_ready = 1'b1;
        wait_done(100);
        check("bp_rd_cnt", rd_cnt, 20);
        check("bp_wr_cnt", wr_cnt, 20);
        check("bp_queue_empty", wr_exp.size(), 0);
        tick(2);

        // Reset during DRAIN
        start_job(10, 400, 10, c);
        tick(11);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        rd_exp.delete();
        wr_exp.delete();
        check_zero_outputs("midreset");
        wr_valid_cnt = 0;
        tick(20);
        check("midreset_no_wr_valid", wr_valid_cnt, 0);
        tick(2);

        // Count clamp
        start_job(0, 0, 1100, c);
        wait_done(1200);
        check("clamp_rd_cnt", rd_cnt, 1024);
        check("clamp_wr_cnt", wr_cnt, 1024);
        check("clamp_done_cyc", done_cyc, c + 1024 + 8);
        check("clamp_queue_empty", wr_exp.size(), 0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
